// File: rtl/load_store_unit.sv
// Byte-addressed load/store front end for a word-wide single-port data memory.
// Big-endian lanes; sub-word stores use read-modify-write.
module load_store_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_store,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  output logic                  mem_wr_rd,
  input  logic [DATA_WIDTH-1:0] mem_dout
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RD_ISSUE = 3'd1;
  localparam logic [2:0] S_RD_DATA  = 3'd2;
  localparam logic [2:0] S_WRITE    = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [1:0]            off_q, off_d;
  logic [1:0]            size_q, size_d;
  logic                  store_q, store_d;
  logic                  signed_q, signed_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           mem_din_q, mem_din_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic        err_c;
  logic [4:0]  shamt;
  logic [31:0] mask;
  logic [31:0] lane;
  logic        sign_bit;
  logic [31:0] load_val;
  logic [31:0] merged;

  always_comb begin
    err_c = (req_size == 2'b11)
         || (req_size == 2'b01 && req_addr[0])
         || (req_size == 2'b10 && req_addr[1:0] != 2'b00)
         || ((req_addr >> (ADDR_WIDTH + 2)) != '0);
  end

  // Offset 0 is the most significant lane, so the shift counts down.
  always_comb begin
    shamt = '0;
    mask  = '1;
    unique case (size_q)
      2'b00: begin
        shamt = {~off_q, 3'b000};
        mask  = 32'h0000_00FF;
      end
      2'b01: begin
        shamt = {~off_q[1], 4'b0000};
        mask  = 32'h0000_FFFF;
      end
      default: ;
    endcase
    lane     = (mem_dout >> shamt) & mask;
    sign_bit = (size_q == 2'b00) ? lane[7] : lane[15];
    load_val = (signed_q && sign_bit) ? (lane | ~mask) : lane;
    merged   = (mem_dout & ~(mask << shamt))
             | ((wdata_q & mask) << shamt);
  end

  always_comb begin
    state_d    = state_q;
    mem_addr_d = mem_addr_q;
    off_d      = off_q;
    size_d     = size_q;
    store_d    = store_q;
    signed_d   = signed_q;
    wdata_d    = wdata_q;
    mem_din_d  = mem_din_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          mem_addr_d = req_addr[ADDR_WIDTH+1:2];
          off_d      = req_addr[1:0];
          size_d     = req_size;
          store_d    = req_store;
          signed_d   = req_signed;
          wdata_d    = req_wdata;
          rdata_d    = '0;
          err_d      = err_c;
          if (err_c) begin
            state_d = S_DONE;
          end else if (req_store && req_size == 2'b10) begin
            mem_din_d = req_wdata;
            state_d   = S_WRITE;
          end else begin
            state_d = S_RD_ISSUE;
          end
        end
      end
      S_RD_ISSUE: state_d = S_RD_DATA;
      S_RD_DATA: begin
        if (store_q) begin
          mem_din_d = merged;
          state_d   = S_WRITE;
        end else begin
          rdata_d = load_val;
          state_d = S_DONE;
        end
      end
      S_WRITE: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      mem_addr_q <= '0;
      off_q      <= '0;
      size_q     <= '0;
      store_q    <= 1'b0;
      signed_q   <= 1'b0;
      wdata_q    <= '0;
      mem_din_q  <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_addr_q <= mem_addr_d;
      off_q      <= off_d;
      size_q     <= size_d;
      store_q    <= store_d;
      signed_q   <= signed_d;
      wdata_q    <= wdata_d;
      mem_din_q  <= mem_din_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  // Write strobe decoded from state so a reset drops any pending write.
  assign mem_wr_rd  = (state_q == S_WRITE);
  assign resp_valid = (state_q == S_DONE);
  assign req_ready  = rst_n && (state_q == S_IDLE);
  assign mem_addr   = mem_addr_q;
  assign mem_din    = mem_din_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed cases plus random traffic
// against a byte-array reference of the big-endian memory.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [10:0] mem_addr;
  logic [31:0] mem_din;
  logic        mem_wr_rd;
  logic [31:0] mem_dout;

  always #5 clk = ~clk;

  load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(11)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_store(req_store), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_wr_rd(mem_wr_rd), .mem_dout(mem_dout)
  );

  logic [31:0] mem_arr [0:2047];
  always_ff @(posedge clk) begin
    if (mem_wr_rd) mem_arr[mem_addr] <= mem_din;
    mem_dout <= mem_arr[mem_addr];
  end

  logic [7:0] ref_bytes [0:8191];
  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {ref_bytes[a], ref_bytes[a+1], ref_bytes[a+2], ref_bytes[a+3]};
  endfunction

  function automatic void model(input logic st, input logic [1:0] sz,
                                input logic sg, input logic [31:0] a,
                                input logic [31:0] wd, output logic e,
                                output logic [31:0] rd, output int nwr,
                                output logic [31:0] ww);
    int n;
    logic [31:0] v;
    n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    e   = (sz == 2'd3) || (a % n != 0) || (a >= 32'h2000);
    rd  = '0;
    nwr = 0;
    ww  = '0;
    if (e) return;
    if (st) begin
      for (int i = 0; i < n; i++) ref_bytes[a+i] = wd[8*(n-1-i) +: 8];
      nwr = 1;
      ww  = word_at(a & ~32'd3);
    end else begin
      v = '0;
      for (int i = 0; i < n; i++) v = (v << 8) | 32'(ref_bytes[a+i]);
      if (sg && n < 4 && v[8*n-1]) v = v - (32'd1 << (8*n));
      rd = v;
    end
  endfunction

  task automatic do_req(input logic st, input logic [1:0] sz,
                        input logic sg, input logic [31:0] a,
                        input logic [31:0] wd);
    logic e;
    logic [31:0] rd, ww, waddr, wdin;
    int nw, lat, exp_lat, wcnt;
    bit got;
    model(st, sz, sg, a, wd, e, rd, nw, ww);
    exp_lat = e ? 1 : (st ? ((sz == 2'd2) ? 2 : 4) : 3);
    @(negedge clk);
    check("ready_idle", req_ready, 1);
    req_valid = 1; req_store = st; req_size = sz;
    req_signed = sg; req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 0;
    wcnt = 0; got = 0; lat = 0; waddr = '0; wdin = '0;
    for (int c = 1; c <= 8 && !got; c++) begin
      @(negedge clk);
      if (mem_wr_rd) begin
        wcnt++; waddr = 32'(mem_addr); wdin = mem_din;
      end
      if (resp_valid) begin
        got = 1; lat = c;
      end
    end
    check("resp_seen", 32'(got), 1);
    check("latency", lat, exp_lat);
    check("resp_err", 32'(resp_err), 32'(e));
    check("resp_rdata", resp_rdata, rd);
    check("write_count", wcnt, nw);
    if (nw == 1 && wcnt == 1) begin
      check("write_addr", waddr, a >> 2);
      check("write_data", wdin, ww);
    end
  endtask

  initial begin
    logic e;
    logic [31:0] rd, ww, a;
    int nw, n, r;
    logic [1:0] sz;
    int rdy_exp [5] = '{0, 0, 1, 0, 0};
    int val_exp [5] = '{0, 1, 0, 0, 1};
    int wr_exp  [5] = '{1, 0, 0, 1, 0};
    logic [31:0] hs_addr [5];

    for (int i = 0; i < 8192; i++) ref_bytes[i] = 8'h00;
    rst_n = 0; req_valid = 0; req_store = 0; req_size = 0;
    req_signed = 0; req_addr = 0; req_wdata = 0;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(req_ready), 0);
    check("rst_valid", 32'(resp_valid), 0);
    check("rst_wr", 32'(mem_wr_rd), 0);
    check("rst_addr", 32'(mem_addr), 0);
    check("rst_din", mem_din, 0);
    check("rst_rdata", resp_rdata, 0);
    check("rst_err", 32'(resp_err), 0);
    rst_n = 1;

    do_req(1, 2'd2, 0, 32'h10, 32'hDEADBEEF);
    do_req(1, 2'd2, 0, 32'h10, 32'h11223344);
    do_req(1, 2'd0, 0, 32'h11, 32'h000000AA);
    do_req(0, 2'd2, 0, 32'h10, 32'h0);
    check("ld_merged", resp_rdata, 32'h11AA3344);

    do_req(1, 2'd2, 0, 32'h20, 32'h80FF7F01);
    do_req(0, 2'd0, 1, 32'h21, 32'h0);
    check("ld_sb", resp_rdata, 32'hFFFFFFFF);
    do_req(0, 2'd0, 0, 32'h21, 32'h0);
    check("ld_ub", resp_rdata, 32'h000000FF);
    do_req(0, 2'd1, 1, 32'h22, 32'h0);
    check("ld_sh_lo", resp_rdata, 32'h00007F01);
    do_req(0, 2'd1, 1, 32'h20, 32'h0);
    check("ld_sh_hi", resp_rdata, 32'hFFFF80FF);

    do_req(0, 2'd1, 1, 32'h13, 32'h0);
    do_req(0, 2'd2, 0, 32'h12, 32'h0);
    do_req(0, 2'd3, 0, 32'h10, 32'h0);
    do_req(0, 2'd2, 0, 32'h00002000, 32'h0);
    do_req(1, 2'd1, 0, 32'h13, 32'h0000FFFF);

    // Halfword store interrupted by reset in its RD_DATA cycle.
    do_req(1, 2'd2, 0, 32'h40, 32'hCAFEF00D);
    @(negedge clk);
    req_valid = 1; req_store = 1; req_size = 2'd1;
    req_addr = 32'h42; req_wdata = 32'h1234;
    @(posedge clk);
    #1 req_valid = 0;
    @(negedge clk);
    @(negedge clk);
    check("mid_wr_before", 32'(mem_wr_rd), 0);
    rst_n = 0;
    #1;
    check("mid_valid", 32'(resp_valid), 0);
    check("mid_wr", 32'(mem_wr_rd), 0);
    check("mid_addr", 32'(mem_addr), 0);
    check("mid_din", mem_din, 0);
    check("mid_rdata", resp_rdata, 0);
    check("mid_err", 32'(resp_err), 0);
    check("mid_ready", 32'(req_ready), 0);
    @(negedge clk);
    check("mid_wr_after", 32'(mem_wr_rd), 0);
    rst_n = 1;
    @(negedge clk);
    check("mid_ready_rel", 32'(req_ready), 1);
    do_req(0, 2'd2, 0, 32'h40, 32'h0);
    check("mid_mem", resp_rdata, 32'hCAFEF00D);

    // Back-to-back word stores with req_valid held high.
    model(1, 2'd2, 0, 32'h80, 32'hA5A5A5A5, e, rd, nw, ww);
    model(1, 2'd2, 0, 32'h84, 32'h5A5A5A5A, e, rd, nw, ww);
    @(negedge clk);
    req_valid = 1; req_store = 1; req_size = 2'd2; req_signed = 0;
    req_addr = 32'h80; req_wdata = 32'hA5A5A5A5;
    @(posedge clk);
    #1 req_addr = 32'h84; req_wdata = 32'h5A5A5A5A;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("hs_ready", 32'(req_ready), rdy_exp[c]);
      check("hs_valid", 32'(resp_valid), val_exp[c]);
      check("hs_wr", 32'(mem_wr_rd), wr_exp[c]);
      hs_addr[c] = 32'(mem_addr);
    end
    req_valid = 0;
    check("hs_addr1", hs_addr[0], 32'h20);
    check("hs_addr2", hs_addr[3], 32'h21);
    do_req(0, 2'd2, 0, 32'h80, 32'h0);
    do_req(0, 2'd2, 0, 32'h84, 32'h0);

    for (int w = 0; w < 256; w++) do_req(1, 2'd2, 0, 32'(w * 4), $urandom);
    for (int k = 0; k < 200; k++) begin
      sz = 2'($urandom_range(0, 3));
      n  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      a  = 32'($urandom_range(0, 1023));
      r  = $urandom_range(0, 9);
      if (r == 0) a = a | (32'd1 << $urandom_range(13, 31));
      else if (r < 8) a = a & ~32'(n - 1);
      do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
             a, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
